// File: rtl/addr_latch_incdec_if.sv
`default_nettype none
// ============================================================================
// Module   : addr_latch_incdec_if
// Purpose  : Address-side bus bundle between the register file and the
//            address latch / incrementer-decrementer.
// Ports    : db_lo_as_in/db_hi_as_in  value offered by the register file
//            ctl_*                    sequencer controls
//            abus                     external address pins
//            db_lo_as_out/db_hi_as_out, db_as_oe  write-back path
//            result_valid, inc_zero, inc_carry  status
// Modports : master (register file / sequencer side), slave (latch side)
// Revision : 1.0  initial release
// ============================================================================
interface addr_latch_incdec_if;
  logic [7:0]  db_lo_as_in;
  logic [7:0]  db_hi_as_in;
  logic        ctl_al_we;
  logic        ctl_inc_en;
  logic        ctl_inc_dec;
  logic        ctl_inc_limit7;
  logic        ctl_bus_inc_oe;
  logic [15:0] abus;
  logic [7:0]  db_lo_as_out;
  logic [7:0]  db_hi_as_out;
  logic        db_as_oe;
  logic        result_valid;
  logic        inc_zero;
  logic        inc_carry;

  modport master (
    output db_lo_as_in, db_hi_as_in, ctl_al_we, ctl_inc_en, ctl_inc_dec,
           ctl_inc_limit7, ctl_bus_inc_oe,
    input  abus, db_lo_as_out, db_hi_as_out, db_as_oe, result_valid,
           inc_zero, inc_carry
  );

  modport slave (
    input  db_lo_as_in, db_hi_as_in, ctl_al_we, ctl_inc_en, ctl_inc_dec,
           ctl_inc_limit7, ctl_bus_inc_oe,
    output abus, db_lo_as_out, db_hi_as_out, db_as_oe, result_valid,
           inc_zero, inc_carry
  );
endinterface
`default_nettype wire

// File: rtl/addr_latch_incdec.sv
`default_nettype none
// ============================================================================
// Module   : addr_latch_incdec
// Purpose  : Latches a 16-bit address from the address-side buses, drives it
//            to the address pins and computes +/-1 for write-back to the
//            register file. Flags zero results (block-instruction end) and
//            16-bit (or 7-bit) wrap.
// Ports    : clk    system clock, rising edge
//            reset  synchronous active-high reset
//            bus    addr_latch_incdec_if.slave (data, controls, status)
// Config   : ADDR_LIMIT7_EN  when defined, ctl_inc_limit7 confines the
//            carry/borrow to bits [6:0] (R-register refresh); otherwise the
//            input is ignored and arithmetic is always 16-bit.
// Revision : 1.0  initial release
// ============================================================================
module addr_latch_incdec (
  input  logic                clk,
  input  logic                reset,
  addr_latch_incdec_if.slave  bus
);

`ifdef ADDR_LIMIT7_EN
  localparam logic c_LIMIT7_EN = 1'b1;
`else
  localparam logic c_LIMIT7_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LATCHED = 2'd1,
    S_RESULT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] al_q, al_d;
  logic [15:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;

  logic [15:0] w_din;
  logic [15:0] w_op;
  logic [15:0] w_full;
  logic        w_full_wrap;
  logic [6:0]  w_low7;
  logic        w_low7_wrap;
  logic        w_use7;
  logic [15:0] w_next;
  logic        w_next_wrap;

  assign w_din = {bus.db_hi_as_in, bus.db_lo_as_in};

  // A chained step works on the pending result; a first step on the latch.
  assign w_op = (state_q == S_RESULT) ? res_q : al_q;

  always_comb begin
    w_full      = bus.ctl_inc_dec ? (w_op - 16'd1) : (w_op + 16'd1);
    w_full_wrap = bus.ctl_inc_dec ? (w_op == 16'h0000) : (w_op == 16'hFFFF);
    w_low7      = bus.ctl_inc_dec ? (w_op[6:0] - 7'd1) : (w_op[6:0] + 7'd1);
    w_low7_wrap = bus.ctl_inc_dec ? (w_op[6:0] == 7'h00) : (w_op[6:0] == 7'h7F);
    // The control input is read in both builds; the constant masks it off
    // when the refresh mode is not compiled in.
    w_use7      = c_LIMIT7_EN & bus.ctl_inc_limit7;
    w_next      = w_use7 ? {w_op[15:7], w_low7} : w_full;
    w_next_wrap = w_use7 ? w_low7_wrap : w_full_wrap;
  end

  always_comb begin
    state_d = state_q;
    al_d    = al_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ctl_al_we) begin
          al_d    = w_din;
          state_d = S_LATCHED;
        end
      end
      S_LATCHED: begin
        if (bus.ctl_al_we) begin
          al_d = w_din;
        end else if (bus.ctl_inc_en) begin
          res_d   = w_next;
          zero_d  = (w_next == 16'h0000);
          carry_d = w_next_wrap;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        // A reload wins over write-back; the bus still shows the old result
        // during that cycle because the output mux follows state_q.
        if (bus.ctl_al_we) begin
          al_d    = w_din;
          state_d = S_LATCHED;
        end else if (bus.ctl_bus_inc_oe) begin
          state_d = S_IDLE;
        end else if (bus.ctl_inc_en) begin
          res_d   = w_next;
          zero_d  = (w_next == 16'h0000);
          carry_d = w_next_wrap;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      al_q    <= 16'h0000;
      res_q   <= 16'h0000;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      al_q    <= al_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.abus         = al_q;
  assign bus.db_as_oe     = bus.ctl_bus_inc_oe;
  assign bus.db_hi_as_out = (state_q == S_RESULT) ? res_q[15:8] : al_q[15:8];
  assign bus.db_lo_as_out = (state_q == S_RESULT) ? res_q[7:0]  : al_q[7:0];
  assign bus.result_valid = (state_q == S_RESULT);
  assign bus.inc_zero     = zero_q;
  assign bus.inc_carry    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_latch_incdec.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr_latch_incdec
// Purpose  : Self-checking bench for addr_latch_incdec: directed scenarios
//            with spec-derived constants plus a randomized run against an
//            arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_addr_latch_incdec;

`ifdef ADDR_LIMIT7_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LAT  = 1;
  localparam int M_RES  = 2;

  logic clk = 1'b0;
  logic reset;
  addr_latch_incdec_if bus ();

  addr_latch_incdec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: value held for the pins, pending result, phase, flags.
  int m_al, m_res, m_mode;
  bit m_z, m_c;

  function automatic void step(input int base, input bit dec, input bit lim,
                               output int nv, output bit z, output bit c);
    int low;
    if (lim && LIM_EN) begin
      low = base % 128;
      nv  = (base - low) + ((low + (dec ? 127 : 1)) % 128);
      c   = dec ? (low == 0) : (low == 127);
    end else begin
      nv = (base + (dec ? 65535 : 1)) % 65536;
      c  = dec ? (base == 0) : (base == 65535);
    end
    z = (nv == 0);
  endfunction

  task automatic model_edge();
    int din;
    din = {bus.db_hi_as_in, bus.db_lo_as_in};
    if (reset) begin
      m_al = 0; m_res = 0; m_mode = M_IDLE; m_z = 0; m_c = 0;
    end else if (m_mode == M_IDLE) begin
      if (bus.ctl_al_we) begin m_al = din; m_mode = M_LAT; end
    end else if (m_mode == M_LAT) begin
      if (bus.ctl_al_we) m_al = din;
      else if (bus.ctl_inc_en) begin
        step(m_al, bus.ctl_inc_dec, bus.ctl_inc_limit7, m_res, m_z, m_c);
        m_mode = M_RES;
      end
    end else begin
      if (bus.ctl_al_we) begin m_al = din; m_mode = M_LAT; end
      else if (bus.ctl_bus_inc_oe) m_mode = M_IDLE;
      else if (bus.ctl_inc_en)
        step(m_res, bus.ctl_inc_dec, bus.ctl_inc_limit7, m_res, m_z, m_c);
    end
  endtask

  // Apply controls at the falling edge, then settle 1 time unit.
  task automatic drive(input bit rst, input bit we, input bit inc, input bit dec,
                       input bit lim, input bit oe, input logic [15:0] d);
    @(negedge clk);
    reset              = rst;
    bus.ctl_al_we      = we;
    bus.ctl_inc_en     = inc;
    bus.ctl_inc_dec    = dec;
    bus.ctl_inc_limit7 = lim;
    bus.ctl_bus_inc_oe = oe;
    bus.db_hi_as_in    = d[15:8];
    bus.db_lo_as_in    = d[7:0];
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 1, 16'hFFFF);
    n_checks++;
    if (bus.db_as_oe !== 1'b1) begin
      n_errors++; $display("FAIL reset_oe: got %b want 1", bus.db_as_oe);
    end
    clock_edge();
    n_checks++;
    if ({bus.abus, bus.result_valid, bus.inc_zero, bus.inc_carry} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_state: abus=%h rv=%b z=%b c=%b want 0000/0/0/0",
               bus.abus, bus.result_valid, bus.inc_zero, bus.inc_carry);
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0000);
    clock_edge();
  endtask

  task automatic test_inc_writeback();
    drive(0, 1, 0, 0, 0, 0, 16'h1234); clock_edge();
    n_checks++;
    if (bus.abus !== 16'h1234) begin
      n_errors++; $display("FAIL latch_abus: got %h want 1234", bus.abus);
    end
    drive(0, 0, 1, 0, 0, 0, 16'h0000); clock_edge();
    n_checks++;
    if (bus.result_valid !== 1'b1) begin
      n_errors++; $display("FAIL inc_valid: got %b want 1", bus.result_valid);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out, bus.db_as_oe} !== {16'h1235, 1'b1}) begin
      n_errors++; $display("FAIL inc_writeback: got %h%h oe=%b want 1235 oe=1",
                           bus.db_hi_as_out, bus.db_lo_as_out, bus.db_as_oe);
    end
    clock_edge();
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.abus !== 16'h1234) begin
      n_errors++; $display("FAIL consume: rv=%b abus=%h want 0 1234",
                           bus.result_valid, bus.abus);
    end
    // Back in idle: a compute request must be ignored.
    drive(0, 0, 1, 0, 0, 0, 16'h0000); clock_edge();
    n_checks++;
    if (bus.result_valid !== 1'b0) begin
      n_errors++; $display("FAIL idle_inc_ignored: rv=%b want 0", bus.result_valid);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 0, 0, 16'hFFFF); clock_edge();
    drive(0, 0, 1, 0, 0, 0, 16'h0000); clock_edge();
    n_checks++;
    if ({bus.inc_zero, bus.inc_carry} !== 2'b11) begin
      n_errors++; $display("FAIL inc_wrap_flags: z=%b c=%b want 1 1",
                           bus.inc_zero, bus.inc_carry);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out} !== 16'h0000) begin
      n_errors++; $display("FAIL inc_wrap_res: got %h%h want 0000",
                           bus.db_hi_as_out, bus.db_lo_as_out);
    end
    clock_edge();
    drive(0, 1, 0, 0, 0, 0, 16'h0000); clock_edge();
    drive(0, 0, 1, 1, 0, 0, 16'h0000); clock_edge();
    n_checks++;
    if ({bus.inc_zero, bus.inc_carry} !== 2'b01) begin
      n_errors++; $display("FAIL dec_wrap_flags: z=%b c=%b want 0 1",
                           bus.inc_zero, bus.inc_carry);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out} !== 16'hFFFF) begin
      n_errors++; $display("FAIL dec_wrap_res: got %h%h want FFFF",
                           bus.db_hi_as_out, bus.db_lo_as_out);
    end
    clock_edge();
  endtask

  task automatic test_bc_zero_chain();
    drive(0, 1, 0, 0, 0, 0, 16'h0001); clock_edge();
    drive(0, 0, 1, 1, 0, 0, 16'h0000); clock_edge();
    n_checks++;
    if ({bus.inc_zero, bus.inc_carry} !== 2'b10) begin
      n_errors++; $display("FAIL bc_zero: z=%b c=%b want 1 0",
                           bus.inc_zero, bus.inc_carry);
    end
    // Reload while a result is pending, then three chained decrements.
    drive(0, 1, 0, 0, 0, 0, 16'h0003); clock_edge();
    n_checks++;
    if (bus.result_valid !== 1'b0 || bus.abus !== 16'h0003) begin
      n_errors++; $display("FAIL reload_discard: rv=%b abus=%h want 0 0003",
                           bus.result_valid, bus.abus);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 16'h0000); clock_edge();
      n_checks++;
      if (bus.inc_zero !== (i == 2)) begin
        n_errors++; $display("FAIL chain_zero step%0d: z=%b want %b",
                             i, bus.inc_zero, (i == 2));
      end
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out, bus.result_valid} !== {16'h0000, 1'b1}) begin
      n_errors++; $display("FAIL chain_res: got %h%h rv=%b want 0000 rv=1",
                           bus.db_hi_as_out, bus.db_lo_as_out, bus.result_valid);
    end
    clock_edge();
  endtask

  task automatic test_we_oe_collision();
    drive(0, 1, 0, 0, 0, 0, 16'h1234); clock_edge();
    drive(0, 0, 1, 0, 0, 0, 16'h0000); clock_edge();
    drive(0, 1, 0, 0, 0, 1, 16'h5678);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out} !== 16'h1235) begin
      n_errors++; $display("FAIL collide_bus: got %h%h want 1235",
                           bus.db_hi_as_out, bus.db_lo_as_out);
    end
    clock_edge();
    n_checks++;
    if (bus.abus !== 16'h5678 || bus.result_valid !== 1'b0) begin
      n_errors++; $display("FAIL collide_state: abus=%h rv=%b want 5678 0",
                           bus.abus, bus.result_valid);
    end
    // Still latched (not idle): a compute request must be honoured.
    drive(0, 0, 1, 0, 0, 0, 16'h0000); clock_edge();
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out, bus.result_valid} !== {16'h5679, 1'b1}) begin
      n_errors++; $display("FAIL collide_latched: got %h%h rv=%b want 5679 rv=1",
                           bus.db_hi_as_out, bus.db_lo_as_out, bus.result_valid);
    end
    clock_edge();
  endtask

  task automatic test_limit7();
    logic [15:0] exp_res;
    logic        exp_c;
    exp_res = LIM_EN ? 16'h8000 : 16'h8080;
    exp_c   = LIM_EN;
    drive(0, 1, 0, 0, 0, 0, 16'h807F); clock_edge();
    drive(0, 0, 1, 0, 1, 0, 16'h0000); clock_edge();
    n_checks++;
    if (bus.inc_carry !== exp_c || bus.inc_zero !== 1'b0) begin
      n_errors++; $display("FAIL limit7_flags: c=%b z=%b want %b 0",
                           bus.inc_carry, bus.inc_zero, exp_c);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0000);
    n_checks++;
    if ({bus.db_hi_as_out, bus.db_lo_as_out} !== exp_res) begin
      n_errors++; $display("FAIL limit7_res: got %h%h want %h",
                           bus.db_hi_as_out, bus.db_lo_as_out, exp_res);
    end
    clock_edge();
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] exp_out;
    for (int i = 0; i < 400; i++) begin
      d = 16'($urandom);
      // Bias toward boundary values so wraps and zeros are exercised.
      case ($urandom_range(0, 7))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        2: d = 16'h0001;
        3: d = {d[15:7], 7'h7F};
        default: ;
      endcase
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 4) == 0), d);
      exp_out = (m_mode == M_RES) ? 16'(m_res) : 16'(m_al);
      n_checks++;
      if ({bus.db_hi_as_out, bus.db_lo_as_out, bus.db_as_oe} !==
          {exp_out, bus.ctl_bus_inc_oe}) begin
        n_errors++; $display("FAIL rand_bus cyc%0d: got %h%h oe=%b want %h oe=%b", i,
                             bus.db_hi_as_out, bus.db_lo_as_out, bus.db_as_oe,
                             exp_out, bus.ctl_bus_inc_oe);
      end
      clock_edge();
      n_checks++;
      if ({bus.abus, bus.result_valid, bus.inc_zero, bus.inc_carry} !==
          {16'(m_al), (m_mode == M_RES), m_z, m_c}) begin
        n_errors++; $display("FAIL rand_state cyc%0d: abus=%h rv=%b z=%b c=%b want %h %b %b %b",
                             i, bus.abus, bus.result_valid, bus.inc_zero, bus.inc_carry,
                             16'(m_al), (m_mode == M_RES), m_z, m_c);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ctl_al_we = 0; bus.ctl_inc_en = 0; bus.ctl_inc_dec = 0;
    bus.ctl_inc_limit7 = 0; bus.ctl_bus_inc_oe = 0;
    bus.db_hi_as_in = 0; bus.db_lo_as_in = 0;
    m_al = 0; m_res = 0; m_mode = M_IDLE; m_z = 0; m_c = 0;
    test_reset();
    test_inc_writeback();
    test_wrap();
    test_bc_zero_chain();
    test_we_oe_collision();
    test_limit7();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
